apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_pkg.sv | 24 ++
 rtl/apb_addr_decode.sv | 35 +++
 rtl/apb_master_bridge.sv | 167 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default constants for the APB requester bridge.
//   state_e : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   rsp_t   : captured response (rdata, err, timeout)
//   *_DEF   : default values for the NSLV, SLV_SHIFT and TIMEOUT parameters
package apb_master_pkg;

  localparam int NSLV_DEF      = 4;
  localparam int SLV_SHIFT_DEF = 12;
  localparam int TIMEOUT_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave-select decode for the APB requester bridge.
//   addr_i : 32-bit command address
//   psel_o : one-hot slave select (all zero when out of range)
//   oor_o  : address selects no existing slave
// The slave index is the IDXW-bit field starting at SLV_SHIFT. Any set bit
// above that field, or an index at or beyond NSLV (non power-of-two NSLV),
// makes the address out of range.
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter int NSLV      = NSLV_DEF,
  parameter int SLV_SHIFT = SLV_SHIFT_DEF
) (
  input  logic [31:0]     addr_i,
  output logic [NSLV-1:0] psel_o,
  output logic            oor_o
);

  localparam int IDXW   = (NSLV > 1) ? $clog2(NSLV) : 0;
  localparam int HI_LSB = SLV_SHIFT + IDXW;

  logic [31:0] idx;
  logic [31:0] hi;

  always_comb begin
    idx    = (addr_i >> SLV_SHIFT) & ((32'd1 << IDXW) - 32'd1);
    hi     = addr_i >> HI_LSB;
    oor_o  = (hi != 32'd0) || (idx >= 32'(NSLV));
    psel_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      psel_o[i] = !oor_o && (idx == 32'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB requester bridge.
// Ports:
//   PCLK, PRESET                  : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake, cmd_addr/cmd_write/cmd_wdata
//   rsp_valid/rsp_ready           : response handshake, rsp_rdata/rsp_err/rsp_timeout
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL : APB requester outputs (PSEL one-hot, NSLV wide)
//   PRDATA/PREADY/PSLVERR         : APB completer returns, only looked at in ACCESS
// One transfer at a time: IDLE -> SETUP -> ACCESS (until PREADY or TIMEOUT
// cycles) -> RESP (until rsp_ready) -> IDLE. Out-of-range commands skip the
// bus and go straight to RESP with an error.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int NSLV      = NSLV_DEF,
  parameter int SLV_SHIFT = SLV_SHIFT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_addr,
  input  logic            cmd_write,
  input  logic [31:0]     cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [31:0]     PADDR,
  output logic [31:0]     PWDATA,
  output logic            PWRITE,
  output logic            PENABLE,
  output logic [NSLV-1:0] PSEL,
  input  logic [31:0]     PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);

  // Last ACCESS cycle index; the counter starts at 0 in the first ACCESS cycle.
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  rsp_t            rsp_q, rsp_d;
  logic [7:0]      tcnt_q, tcnt_d;

  logic [NSLV-1:0] dec_psel;
  logic            dec_oor;

  apb_addr_decode #(
    .NSLV      (NSLV),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_decode (
    .addr_i (cmd_addr),
    .psel_o (dec_psel),
    .oor_o  (dec_oor)
  );

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rsp_d     = rsp_q;
    tcnt_d    = tcnt_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is registered so it stays low until the first edge
        // after reset release.
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          ready_d  = 1'b0;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : 32'd0;
          if (dec_oor) begin
            state_d = RESP;
            rsp_d   = '{rdata: 32'd0, err: 1'b1, timeout: 1'b0};
          end else begin
            state_d = SETUP;
            psel_d  = dec_psel;
            tcnt_d  = 8'd0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PREADY is checked first so completion on the terminal count wins.
        if (PREADY) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          rsp_d     = '{rdata: (pwrite_q ? 32'd0 : PRDATA), err: PSLVERR, timeout: 1'b0};
        end else if (tcnt_q == TLAST) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          rsp_d     = '{rdata: 32'd0, err: 1'b1, timeout: 1'b1};
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      rsp_q     <= '0;
      tcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rsp_q     <= rsp_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PENABLE     = penable_q;
  assign PSEL        = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int NSLV = 4;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [31:0]     cmd_addr = 32'd0;
  logic            cmd_write = 1'b0;
  logic [31:0]     cmd_wdata = 32'd0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            rsp_timeout;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE;
  logic            PENABLE;
  logic [NSLV-1:0] PSEL;
  logic [31:0]     PRDATA = 32'd0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  apb_master_bridge #(.NSLV(NSLV), .SLV_SHIFT(12), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // PSEL must never have more than one bit set.
  always @(negedge PCLK) begin
    if (!$onehot0(PSEL)) begin
      chk_cnt++;
      $display("FAIL psel_onehot: got %b", PSEL);
    end
  end

  // Stimulus: wait for cmd_ready (bounded), present one command for one edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL issue_ready: got %b want 1", cmd_ready);
    else pass_cnt++;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  // Slave model: PREADY low for 'waits' ACCESS cycles, then high for one.
  // Returns ACCESS cycle count and PSEL seen during ACCESS. Bounded.
  task automatic slave_run(input int waits, input logic [31:0] rd, input logic err,
                           output int acc, output logic [NSLV-1:0] acc_psel);
    acc = 0; acc_psel = '0;
    PRDATA = rd; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int c = 0; c < 40 && rsp_valid !== 1'b1; c++) begin
      if (acc == waits + 1) begin PREADY = 1'b1; PSLVERR = err; end
      @(posedge PCLK); #1;
      if (PENABLE === 1'b1) begin acc++; acc_psel = PSEL; end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk_cnt++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0)
      $display("FAIL rst_bus: got psel=%b en=%b wr=%b addr=%h wdata=%h want all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0)
      $display("FAIL rst_rsp: got v=%b e=%b t=%b d=%h want all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready);
    else pass_cnt++;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_write;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'd0, err: 1'b0, to: 1'b0});
    issue(32'h0000_1004, 1'b1, 32'hA5A5_0001);
    chk_cnt++;
    if ({PSEL, PENABLE, PWRITE} !== {4'b0010, 1'b0, 1'b1})
      $display("FAIL wr_setup_ctl: got psel=%b en=%b wr=%b want 0010 0 1", PSEL, PENABLE, PWRITE);
    else pass_cnt++;
    chk_cnt++;
    if ({PADDR, PWDATA} !== {32'h0000_1004, 32'hA5A5_0001})
      $display("FAIL wr_setup_data: got addr=%h wdata=%h want 00001004 a5a50001", PADDR, PWDATA);
    else pass_cnt++;
    slave_run(0, 32'hCAFE_F00D, 1'b0, acc, ps);
    chk_cnt++;
    if (acc !== 1 || ps !== 4'b0010) $display("FAIL wr_access: got cycles=%0d psel=%b want 1 0010", acc, ps);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_valid, PSEL, PENABLE} !== {1'b1, 4'b0000, 1'b0})
      $display("FAIL wr_resp_state: got v=%b psel=%b en=%b want 1 0000 0", rsp_valid, PSEL, PENABLE);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL wr_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to})
        $display("FAIL wr_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
    chk_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL wr_back_idle: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_read_wait;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, to: 1'b0});
    issue(32'h0000_3010, 1'b0, 32'h1234_5678);
    chk_cnt++;
    if ({PSEL, PWRITE, PWDATA} !== {4'b1000, 1'b0, 32'd0})
      $display("FAIL rd_setup: got psel=%b wr=%b wdata=%h want 1000 0 00000000", PSEL, PWRITE, PWDATA);
    else pass_cnt++;
    slave_run(3, 32'hDEAD_BEEF, 1'b0, acc, ps);
    chk_cnt++;
    if (acc !== 4 || rsp_valid !== 1'b1) $display("FAIL rd_access_len: got cycles=%0d v=%b want 4 1", acc, rsp_valid);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL rd_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to})
        $display("FAIL rd_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_slverr;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b1, to: 1'b0});
    issue(32'h0000_0020, 1'b0, 32'd0);
    slave_run(1, 32'h0BAD_F00D, 1'b1, acc, ps);
    chk_cnt++;
    if (acc !== 2 || ps !== 4'b0001) $display("FAIL err_access: got cycles=%0d psel=%b want 2 0001", acc, ps);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL err_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, e.rdata, e.err, e.to})
        $display("FAIL err_rsp: got v=%b %h/%b/%b want 1 %h/%b/%b", rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_timeout;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'd0, err: 1'b1, to: 1'b1});
    issue(32'h0000_2000, 1'b0, 32'd0);
    slave_run(1000, 32'hFFFF_FFFF, 1'b0, acc, ps);
    chk_cnt++;
    if (acc !== 16 || ps !== 4'b0100) $display("FAIL to_access_len: got cycles=%0d psel=%b want 16 0100", acc, ps);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_valid, PSEL, PENABLE} !== {1'b1, 4'b0000, 1'b0})
      $display("FAIL to_resp_state: got v=%b psel=%b en=%b want 1 0000 0", rsp_valid, PSEL, PENABLE);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL to_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to})
        $display("FAIL to_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
  endtask

  // PREADY arriving on the 16th ACCESS cycle completes normally.
  task automatic test_ready_on_terminal;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'h7777_0007, err: 1'b0, to: 1'b0});
    issue(32'h0000_1100, 1'b0, 32'd0);
    slave_run(15, 32'h7777_0007, 1'b0, acc, ps);
    chk_cnt++;
    if (acc !== 16) $display("FAIL term_access_len: got cycles=%0d want 16", acc);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL term_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, e.rdata, e.err, e.to})
        $display("FAIL term_rsp: got v=%b %h/%b/%b want 1 %h/%b/%b", rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_out_of_range;
    exp_t e;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_4000;
    addrs[1] = 32'h8000_1000;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{rdata: 32'd0, err: 1'b1, to: 1'b0});
      PREADY = 1'b1; PRDATA = 32'h5555_AAAA;
      issue(addrs[k], k[0], 32'h1357_9BDF);
      chk_cnt++;
      if ({rsp_valid, PSEL, PENABLE} !== {1'b1, 4'b0000, 1'b0})
        $display("FAIL oor_resp_state[%0d]: got v=%b psel=%b en=%b want 1 0000 0", k, rsp_valid, PSEL, PENABLE);
      else pass_cnt++;
      chk_cnt++;
      if (sb.size() == 0) $display("FAIL oor_rsp[%0d]: scoreboard empty", k);
      else begin
        e = sb.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to})
          $display("FAIL oor_rsp[%0d]: got %h/%b/%b want %h/%b/%b", k, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        else pass_cnt++;
      end
      PREADY = 1'b0;
      @(posedge PCLK); #1;
      chk_cnt++;
      if ({rsp_valid, PSEL} !== {1'b0, 4'b0000}) $display("FAIL oor_idle[%0d]: got v=%b psel=%b want 0 0000", k, rsp_valid, PSEL);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    e = '{rdata: 32'd0, err: 1'b0, to: 1'b0};
    sb.push_back(e);
    rsp_ready = 1'b0;
    issue(32'h0000_0008, 1'b1, 32'h1122_3344);
    slave_run(0, 32'hCAFE_F00D, 1'b0, acc, ps);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_2000; cmd_write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_cnt++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, e.rdata, e.err, e.to})
        $display("FAIL bp_hold[%0d]: got v=%b %h/%b/%b want 1 %h/%b/%b", c, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
      chk_cnt++;
      if ({cmd_ready, PSEL} !== {1'b0, 4'b0000}) $display("FAIL bp_cmd_ready[%0d]: got rdy=%b psel=%b want 0 0000", c, cmd_ready, PSEL);
      else pass_cnt++;
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL bp_rsp: scoreboard empty");
    else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, e.rdata, e.err, e.to})
        $display("FAIL bp_rsp: got v=%b %h/%b/%b want 1 %h/%b/%b", rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
    chk_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    exp_t e; int acc; logic [NSLV-1:0] ps;
    sb.push_back('{rdata: 32'h1111_0001, err: 1'b0, to: 1'b0});
    sb.push_back('{rdata: 32'h2222_0002, err: 1'b0, to: 1'b0});
    for (int k = 0; k < 2; k++) begin
      issue((k == 0) ? 32'h0000_1000 : 32'h0000_2004, 1'b0, 32'd0);
      slave_run(k + 1, (k == 0) ? 32'h1111_0001 : 32'h2222_0002, 1'b0, acc, ps);
      chk_cnt++;
      if (sb.size() == 0) $display("FAIL b2b_rsp[%0d]: scoreboard empty", k);
      else begin
        e = sb.pop_front();
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, e.rdata, e.err, e.to})
          $display("FAIL b2b_rsp[%0d]: got v=%b %h/%b/%b want 1 %h/%b/%b", k, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        else pass_cnt++;
      end
      @(posedge PCLK); #1;
      chk_cnt++;
      if ({cmd_ready, PSEL, PENABLE} !== {1'b1, 4'b0000, 1'b0})
        $display("FAIL b2b_idle_gap[%0d]: got rdy=%b psel=%b en=%b want 1 0000 0", k, cmd_ready, PSEL, PENABLE);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    issue(32'h0000_1000, 1'b1, 32'h55AA_55AA);
    PREADY = 1'b0;
    repeat (2) begin @(posedge PCLK); #1; end
    chk_cnt++;
    if ({PSEL, PENABLE, PWRITE} !== {4'b0010, 1'b1, 1'b1})
      $display("FAIL rm_in_access: got psel=%b en=%b wr=%b want 0010 1 1", PSEL, PENABLE, PWRITE);
    else pass_cnt++;
    PRESET = 1'b1;
    #1;
    chk_cnt++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0)
      $display("FAIL rm_bus_async: got psel=%b en=%b wr=%b addr=%h wdata=%h want all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else pass_cnt++;
    chk_cnt++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0)
      $display("FAIL rm_rsp_async: got rdy=%b v=%b e=%b t=%b d=%h want all 0", cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    else pass_cnt++;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    PREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge PCLK); #1;
      chk_cnt++;
      if ({rsp_valid, PSEL} !== {1'b0, 4'b0000}) $display("FAIL rm_no_rsp[%0d]: got v=%b psel=%b want 0 0000", c, rsp_valid, PSEL);
      else pass_cnt++;
    end
    PREADY = 1'b0;
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", cmd_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_ready_on_terminal();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
